id_exe_stage_reg: RTL and testbench

- Pipeline register between the decode stage (control unit, register file, immediate extraction) and the execute stage of the 5-stage ARM core.
- Captures the 9-bit control bundle plus the decode-stage datapath fields on every enabled clock edge.
- Handles hazard freeze, branch flush and bubble insertion.
- Tracks a valid bit so that downstream write-back and memory enables are never asserted by a squashed slot.

---
 rtl/arm_pkg.sv | 61 ++++++
 rtl/pipe_reg_en_clr.sv | 43 ++++
 rtl/id_exe_stage_reg.sv | 165 ++++++++++++++++
 tb/tb_id_exe_stage_reg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
//
// Purpose:
//   Shared definitions for the 5-stage ARM core pipeline. Holds the bit
//   positions of the 9-bit decode control bundle, the ALU command
//   encodings and the default datapath / register-index widths.
//
// Contents:
//   DATA_W_DEFAULT      default datapath width (PC, operands)
//   REG_ADDR_W_DEFAULT  default register index width
//   CTRL_W_DEFAULT      control bundle width
//   *_BIT / ALU_CMD_*   control bundle field positions
//   alu_cmd_e           ALU command encodings
//   ctrl_bundle_t       packed view of the control bundle
//   ctrl_has_side_effect() true when any state-changing control bit is set
// ---------------------------------------------------------------------------
package arm_pkg;

  localparam int DATA_W_DEFAULT     = 32;
  localparam int REG_ADDR_W_DEFAULT = 4;
  localparam int CTRL_W_DEFAULT     = 9;

  // Control bundle layout: {wb_en, mem_read, mem_write, alu_cmd[3:0], b, s}
  localparam int WB_EN_BIT   = 8;
  localparam int MEM_R_BIT   = 7;
  localparam int MEM_W_BIT   = 6;
  localparam int ALU_CMD_MSB = 5;
  localparam int ALU_CMD_LSB = 2;
  localparam int B_BIT       = 1;
  localparam int S_BIT       = 0;

  typedef enum logic [3:0] {
    ALU_MOV = 4'b0001,
    ALU_MVN = 4'b1001,
    ALU_ADD = 4'b0010,
    ALU_ADC = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_SBC = 4'b0101,
    ALU_AND = 4'b0110,
    ALU_ORR = 4'b0111,
    ALU_EOR = 4'b1000
  } alu_cmd_e;

  typedef struct packed {
    logic       wbEn;
    logic       memRead;
    logic       memWrite;
    logic [3:0] aluCmd;
    logic       b;
    logic       s;
  } ctrl_bundle_t;

  // A slot may only change architectural state through these bits, so a
  // squashed slot must have every one of them at zero.
  function automatic logic ctrl_has_side_effect(input logic [CTRL_W_DEFAULT-1:0] ctrl);
    return ctrl[WB_EN_BIT] | ctrl[MEM_R_BIT] | ctrl[MEM_W_BIT] |
           ctrl[B_BIT] | ctrl[S_BIT];
  endfunction

endpackage

// File: rtl/pipe_reg_en_clr.sv
// ---------------------------------------------------------------------------
// pipe_reg_en_clr
//
// Purpose:
//   Generic width-parameterised pipeline register with asynchronous
//   active-low reset, load enable and synchronous clear. Clear has priority
//   over enable so a squash is never lost behind a stall.
//
// Ports:
//   clk    in   core clock
//   rst_n  in   asynchronous active-low reset, forces q to 0
//   en     in   load d on the next rising edge
//   clr    in   synchronous clear to 0 (overrides en)
//   d      in   W-bit next value
//   q      out  W-bit registered value
// ---------------------------------------------------------------------------
module pipe_reg_en_clr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Reset beats clear, clear beats enable; with neither, the value holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ---------------------------------------------------------------------------
// id_exe_stage_reg
//
// Purpose:
//   ID/EX pipeline register of the 5-stage ARM core. Captures the decode
//   control bundle and datapath fields once per enabled edge, honours
//   hazard freeze and branch flush, and carries a valid bit so that a
//   squashed or bubble slot never drives write-back or memory enables.
//
// Ports (all outputs registered, one cycle after the matching input):
//   clk, rst_n                   clock, asynchronous active-low reset
//   freeze                       hold all state (hazard stall)
//   flush                        squash the slot being captured
//   ctrl_in / ctrl_out           9-bit control bundle
//   pc_in / pc_out               PC+4 of the instruction
//   rn_val_in, rm_val_in / _out  register operands
//   imm_in / imm_out             I bit
//   shift_op_in / shift_op_out   12-bit shifter operand
//   simm24_in / simm24_out       24-bit branch offset
//   dest_in, src1_in, src2_in    register indices (+ _out)
//   sr_in / sr_out               NZCV flags seen at decode
//   valid_in / valid_out         slot holds a live instruction
//
// Optional build (macro ID_EXE_PERF_CNT_EN):
//   stall_cnt_out   cycles with freeze=1 and flush=0
//   flush_cnt_out   cycles with flush=1
//   bubble_cnt_out  loads (no freeze, no flush) with valid_in=0
// ---------------------------------------------------------------------------
module id_exe_stage_reg
  import arm_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int CTRL_W     = CTRL_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     rn_val_in,
  input  logic [DATA_W-1:0]     rm_val_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_op_in,
  input  logic [23:0]           simm24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic [3:0]            sr_in,
  input  logic                  valid_in,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     rn_val_out,
  output logic [DATA_W-1:0]     rm_val_out,
  output logic                  imm_out,
  output logic [11:0]           shift_op_out,
  output logic [23:0]           simm24_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
  output logic [3:0]            sr_out,
  output logic                  valid_out
`ifdef ID_EXE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_out,
  output logic [31:0]           flush_cnt_out,
  output logic [31:0]           bubble_cnt_out
`endif
);

  localparam int CTRL_GRP_W = CTRL_W + 1;
  localparam int DATA_GRP_W = 3 * DATA_W + 1 + 12 + 24 + 4;
  localparam int IDX_GRP_W  = 3 * REG_ADDR_W;

  logic                  w_loadEn;
  logic                  w_ctrlEn;
  logic [CTRL_W-1:0]     w_ctrlGated;
  logic [CTRL_GRP_W-1:0] w_ctrlD;
  logic [CTRL_GRP_W-1:0] w_ctrlQ;
  logic [DATA_GRP_W-1:0] w_dataD;
  logic [DATA_GRP_W-1:0] w_dataQ;
  logic [IDX_GRP_W-1:0]  w_idxD;
  logic [IDX_GRP_W-1:0]  w_idxQ;

  // Data fields are don't-care in a squashed slot, so they load on a flush
  // edge as well; only a plain freeze holds them.
  assign w_loadEn = flush | ~freeze;

  // The control group's synchronous clear handles the flush case, and its
  // enable only has to cover the freeze case.
  assign w_ctrlEn = ~freeze;

  // An invalid upstream slot must never carry live control bits into EX.
  assign w_ctrlGated = valid_in ? ctrl_in : '0;

  assign w_ctrlD = {valid_in, w_ctrlGated};
  assign w_dataD = {pc_in, rn_val_in, rm_val_in, imm_in, shift_op_in,
                    simm24_in, sr_in};
  assign w_idxD  = {dest_in, src1_in, src2_in};

  pipe_reg_en_clr #(.W(CTRL_GRP_W)) u_ctrlReg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_ctrlEn),
    .clr   (flush),
    .d     (w_ctrlD),
    .q     (w_ctrlQ)
  );

  pipe_reg_en_clr #(.W(DATA_GRP_W)) u_dataReg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_loadEn),
    .clr   (1'b0),
    .d     (w_dataD),
    .q     (w_dataQ)
  );

  pipe_reg_en_clr #(.W(IDX_GRP_W)) u_idxReg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_loadEn),
    .clr   (1'b0),
    .d     (w_idxD),
    .q     (w_idxQ)
  );

  assign {valid_out, ctrl_out} = w_ctrlQ;
  assign {pc_out, rn_val_out, rm_val_out, imm_out, shift_op_out,
          simm24_out, sr_out} = w_dataQ;
  assign {dest_out, src1_out, src2_out} = w_idxQ;

`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] r_stallCnt;
  logic [31:0] r_flushCnt;
  logic [31:0] r_bubbleCnt;

  // Performance counters run every cycle regardless of freeze and wrap
  // naturally at 2^32. A bubble is counted only when the register actually
  // loads a fresh slot (no stall, no squash) that arrives invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt  <= '0;
      r_flushCnt  <= '0;
      r_bubbleCnt <= '0;
    end else begin
      if (freeze && !flush) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
      if (flush) begin
        r_flushCnt <= r_flushCnt + 32'd1;
      end
      if (!freeze && !flush && !valid_in) begin
        r_bubbleCnt <= r_bubbleCnt + 32'd1;
      end
    end
  end

  assign stall_cnt_out  = r_stallCnt;
  assign flush_cnt_out  = r_flushCnt;
  assign bubble_cnt_out = r_bubbleCnt;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_exe_stage_reg
//
// Self-checking bench for id_exe_stage_reg. Directed scenarios plus a
// randomized run, all compared against a behavioural model of the
// register kept in the bench. Counter checks are active when
// ID_EXE_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_id_exe_stage_reg;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 9;

  logic          clk;
  logic          rst_n;
  logic          freeze;
  logic          flush;
  logic [CW-1:0] ctrl_in;
  logic [DW-1:0] pc_in, rn_val_in, rm_val_in;
  logic          imm_in;
  logic [11:0]   shift_op_in;
  logic [23:0]   simm24_in;
  logic [AW-1:0] dest_in, src1_in, src2_in;
  logic [3:0]    sr_in;
  logic          valid_in;

  logic [CW-1:0] ctrl_out;
  logic [DW-1:0] pc_out, rn_val_out, rm_val_out;
  logic          imm_out;
  logic [11:0]   shift_op_out;
  logic [23:0]   simm24_out;
  logic [AW-1:0] dest_out, src1_out, src2_out;
  logic [3:0]    sr_out;
  logic          valid_out;
`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0]   stall_cnt_out, flush_cnt_out, bubble_cnt_out;
`endif

  // Expected register contents, updated from the behavioural rules.
  logic [CW-1:0] expCtrl;
  logic [DW-1:0] expPc, expRn, expRm;
  logic          expImm;
  logic [11:0]   expShift;
  logic [23:0]   expSimm;
  logic [AW-1:0] expDest, expSrc1, expSrc2;
  logic [3:0]    expSr;
  logic          expValid;
  logic [31:0]   expStall, expFlush, expBubble;

  int checkCount;
  int errorCount;

  id_exe_stage_reg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .flush        (flush),
    .ctrl_in      (ctrl_in),
    .pc_in        (pc_in),
    .rn_val_in    (rn_val_in),
    .rm_val_in    (rm_val_in),
    .imm_in       (imm_in),
    .shift_op_in  (shift_op_in),
    .simm24_in    (simm24_in),
    .dest_in      (dest_in),
    .src1_in      (src1_in),
    .src2_in      (src2_in),
    .sr_in        (sr_in),
    .valid_in     (valid_in),
    .ctrl_out     (ctrl_out),
    .pc_out       (pc_out),
    .rn_val_out   (rn_val_out),
    .rm_val_out   (rm_val_out),
    .imm_out      (imm_out),
    .shift_op_out (shift_op_out),
    .simm24_out   (simm24_out),
    .dest_out     (dest_out),
    .src1_out     (src1_out),
    .src2_out     (src2_out),
    .sr_out       (sr_out),
    .valid_out    (valid_out)
`ifdef ID_EXE_PERF_CNT_EN
    ,
    .stall_cnt_out  (stall_cnt_out),
    .flush_cnt_out  (flush_cnt_out),
    .bubble_cnt_out (bubble_cnt_out)
`endif
  );

  // Free-running core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Model: everything clears while reset is asserted.
  task automatic modelReset();
    expCtrl = '0; expPc = '0; expRn = '0; expRm = '0; expImm = 1'b0;
    expShift = '0; expSimm = '0; expDest = '0; expSrc1 = '0; expSrc2 = '0;
    expSr = '0; expValid = 1'b0;
    expStall = '0; expFlush = '0; expBubble = '0;
  endtask

  // Model of one rising edge: flush squashes the slot (data still loads),
  // freeze alone holds everything, otherwise the slot is captured with its
  // control gated by valid_in.
  task automatic modelEdge();
    if (flush) expFlush = expFlush + 32'd1;
    else if (freeze) expStall = expStall + 32'd1;
    else if (!valid_in) expBubble = expBubble + 32'd1;

    if (flush || !freeze) begin
      expPc = pc_in; expRn = rn_val_in; expRm = rm_val_in; expImm = imm_in;
      expShift = shift_op_in; expSimm = simm24_in; expDest = dest_in;
      expSrc1 = src1_in; expSrc2 = src2_in; expSr = sr_in;
    end
    if (flush) begin
      expCtrl = '0;
      expValid = 1'b0;
    end else if (!freeze) begin
      expValid = valid_in;
      expCtrl = valid_in ? ctrl_in : 9'd0;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".ctrl"},   32'(ctrl_out),     32'(expCtrl));
    checkOutput({tag, ".valid"},  32'(valid_out),    32'(expValid));
    checkOutput({tag, ".pc"},     pc_out,            expPc);
    checkOutput({tag, ".rn"},     rn_val_out,        expRn);
    checkOutput({tag, ".rm"},     rm_val_out,        expRm);
    checkOutput({tag, ".imm"},    32'(imm_out),      32'(expImm));
    checkOutput({tag, ".shift"},  32'(shift_op_out), 32'(expShift));
    checkOutput({tag, ".simm24"}, 32'(simm24_out),   32'(expSimm));
    checkOutput({tag, ".dest"},   32'(dest_out),     32'(expDest));
    checkOutput({tag, ".src1"},   32'(src1_out),     32'(expSrc1));
    checkOutput({tag, ".src2"},   32'(src2_out),     32'(expSrc2));
    checkOutput({tag, ".sr"},     32'(sr_out),       32'(expSr));
`ifdef ID_EXE_PERF_CNT_EN
    checkOutput({tag, ".stallCnt"},  stall_cnt_out,  expStall);
    checkOutput({tag, ".flushCnt"},  flush_cnt_out,  expFlush);
    checkOutput({tag, ".bubbleCnt"}, bubble_cnt_out, expBubble);
`endif
  endtask

  task automatic randomizeData();
    ctrl_in = CW'($urandom); pc_in = $urandom; rn_val_in = $urandom;
    rm_val_in = $urandom; imm_in = 1'($urandom); shift_op_in = 12'($urandom);
    simm24_in = 24'($urandom); dest_in = AW'($urandom);
    src1_in = AW'($urandom); src2_in = AW'($urandom); sr_in = 4'($urandom);
  endtask

  // Called with inputs already set at a falling edge: take one rising edge,
  // step the model, check shortly after the edge, return at the next
  // falling edge.
  task automatic applyStimulus(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
    @(negedge clk);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; valid_in = 1'b1;
    randomizeData();
    modelReset();
    #2;
    checkAll("resetInit");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD with wb_en, operand passes through in one cycle.
    ctrl_in = 9'b100001000; rn_val_in = 32'h10; valid_in = 1'b1;
    applyStimulus("addLoad");

    // Freeze for three cycles while inputs keep changing, then load.
    for (int i = 0; i < 3; i++) begin
      freeze = 1'b1; flush = 1'b0; valid_in = 1'b1;
      randomizeData();
      applyStimulus($sformatf("freeze%0d", i));
    end
    freeze = 1'b0;
    randomizeData();
    applyStimulus("freezeRelease");

    // Flush together with freeze on a store: squash must win.
    freeze = 1'b1; flush = 1'b1; valid_in = 1'b1;
    ctrl_in = 9'b001001000;
    applyStimulus("flushOverFreeze");
    freeze = 1'b0; flush = 1'b0;

    // Invalid upstream slot carrying stray control bits.
    valid_in = 1'b0; ctrl_in = 9'h1C0;
    applyStimulus("bubble");
    valid_in = 1'b1;

    // Asynchronous reset in the middle of a cycle, held across an edge
    // with freeze and flush both high.
    ctrl_in = 9'h1FF; randomizeData(); ctrl_in = 9'h1FF;
    applyStimulus("preReset");
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll("asyncReset");
    freeze = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    checkAll("resetHold");
    @(negedge clk);
    rst_n = 1'b1; freeze = 1'b0; flush = 1'b0;
    applyStimulus("resetRelease");

`ifdef ID_EXE_PERF_CNT_EN
    // Stall counter wrap: preload all ones, then one stall cycle.
    force dut.r_stallCnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_stallCnt;
    expStall = 32'hFFFF_FFFF;
    freeze = 1'b1; flush = 1'b0;
    applyStimulus("stallWrap");
    freeze = 1'b0;
`endif

    // Randomized traffic with occasional stalls, squashes and bubbles.
    for (int i = 0; i < 300; i++) begin
      randomizeData();
      freeze   = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 6) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      applyStimulus("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
